alu_gen: RTL and testbench
==========================

ALU_GEN -- requirements
Module: alu_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, datapath width in bits, legal range 4..32.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port resetBar, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request an operation; sampled on a rising edge when not busy.
REQ-005 The block SHALL have port op, input, 3, operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHR, 6 SHL, 7 MUL.
REQ-006 The block SHALL have ports doCarryIn and doShiftIn, input, 1 each, enabling flagCarry as ADD carry-in and as shift-in respectively.
REQ-007 The block SHALL have port flagEnable, input, 1, permitting flag update by this operation.
REQ-008 The block SHALL have ports areg and breg, input, WIDTH each, operands.
REQ-009 The block SHALL have ports assertBarR and assertBarH, input, 1 each, active-low enables driving result and resultHi onto dbus.
REQ-010 The block SHALL have port dbus, output (tri-state), WIDTH, shared data bus; 'z when neither enable is low.
REQ-011 The block SHALL have ports busy and done, output, 1 each: MUL in progress, and one-cycle completion pulse.
REQ-012 The block SHALL have port aIsZero, output, 1, combinational (areg == 0).
REQ-013 The block SHALL have ports flagCarry, flagZero, flagNeg and flagOverflow, output, 1 each, registered flags.

Function
REQ-014 On a sampled start, areg, breg, op, doCarryIn, doShiftIn and flagEnable SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-015 The FSM SHALL have states IDLE and MUL; start with op 0..6 SHALL stay in IDLE; start with op 7 SHALL go IDLE->MUL.
REQ-016 Ops 0..6 SHALL register result at the start edge and SHALL pulse done for exactly the following cycle (latency 1).
REQ-017 MUL SHALL be unsigned shift-add: busy high from the start edge for WIDTH cycles, result/resultHi = low/high halves of the 2*WIDTH product, done pulsing the cycle after busy falls, then return to IDLE.
REQ-018 start while busy SHALL be ignored, with no effect on state, operands or flags.
REQ-019 ADD SHALL compute a+b+cin, with cin = flagCarry & doCarryIn; C = carry out of bit WIDTH-1.
REQ-020 SUB SHALL compute a-b modulo 2^WIDTH; C = 1 when a >= b (not-borrow).
REQ-021 ADD/SUB V SHALL be two's-complement signed overflow.
REQ-022 Logic ops SHALL leave C unchanged and set V = 0.
REQ-023 SHR SHALL produce {si, a[WIDTH-1:1]} with C = a[0]; SHL SHALL produce {a[WIDTH-2:0], si} with C = a[WIDTH-1]; si = flagCarry & doShiftIn, sampled at start; shifts SHALL set V = 0.
REQ-024 MUL SHALL set C = V = (resultHi != 0); resultHi SHALL be unchanged by ops 0..6.
REQ-025 Z SHALL be (result == 0) and N SHALL be result[WIDTH-1], for every op.
REQ-026 Flags SHALL update only on the edge that registers the result, and only if the latched flagEnable = 1.
REQ-027 dbus SHALL carry result when assertBarR = 0, else resultHi when assertBarH = 0 (assertBarR has priority), else 'z; dbus SHALL be independent of busy.

Reset
REQ-028 resetBar low SHALL immediately, without a clock, force: state IDLE, busy 0, done 0, result 0, resultHi 0, all flags 0, multiplier counter 0.
REQ-029 Reset during MUL SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Structure
REQ-030 Package alu_gen_pkg SHALL hold the op encoding constants and the FSM state type.
REQ-031 The multiplier SHALL be the sub-module alu_gen_mul (load, step counter, accumulator, finished strobe), with the FSM and flag logic in alu_gen.

Verification (WIDTH=8)
REQ-032 The bench SHALL cover ADD 0xF0+0x20 with flagEnable=1 -> result 0x10, C=1, Z=0, V=0, done one cycle after start.
REQ-033 The bench SHALL cover SUB 0x05-0x05 -> result 0x00, Z=1, C=1; SUB 0x03-0x05 -> 0xFE, C=0, N=1.
REQ-034 The bench SHALL cover MUL 0xFF*0xFF -> busy high 8 cycles, then result 0x01, resultHi 0xFE, C=V=1; a start issued mid-busy is ignored.
REQ-035 The bench SHALL cover flagCarry=1 with doShiftIn=1, SHR 0x02 -> result 0x81, C=0; with flagEnable=0 -> all flags unchanged.
REQ-036 The bench SHALL cover resetBar low at MUL cycle 4 -> busy/flags/result 0 immediately, no done pulse; a following ADD 1+1 -> 0x02.
REQ-037 The bench SHALL cover assertBarR=assertBarH=1 -> dbus 'z; assertBarH=0 alone -> dbus=resultHi; both low -> dbus=result.

Source files
------------

// File: rtl/alu_gen_pkg.sv
// Shared types for the alu_gen block: opcode encoding, controller states and
// the packed status-flag record.
package alu_gen_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHR = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/alu_gen_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, the first one
// folded into the load so the full product is ready WIDTH cycles after load.
module alu_gen_mul
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             finished_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int COUNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Low half holds the not-yet-consumed multiplier bits; the carry out of the
  // high-half add shifts in at the top.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] prod,
                                                  input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    return {sum, prod[WIDTH-1:1]};
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    if (load_i) begin
      mcand_d = a_i;
      prod_d  = mul_step({{WIDTH{1'b0}}, b_i}, a_i);
      count_d = COUNT_W'(1);
    end else if (count_q == COUNT_W'(WIDTH)) begin
      count_d = '0;
    end else if (count_q != '0) begin
      prod_d  = mul_step(prod_q, mcand_q);
      count_d = count_q + COUNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
    end
  end

  assign finished_o = (count_q == COUNT_W'(WIDTH));
  assign lo_o       = prod_q[WIDTH-1:0];
  assign hi_o       = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_gen.sv
// Registered ALU with flags, a multi-cycle multiplier and tri-state bus output.
// Single-cycle ops complete at the start edge; MUL runs for WIDTH cycles.
module alu_gen
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             doCarryIn,
  input  logic             doShiftIn,
  input  logic             flagEnable,
  input  logic [WIDTH-1:0] areg,
  input  logic [WIDTH-1:0] breg,
  input  logic             assertBarR,
  input  logic             assertBarH,
  output logic [WIDTH-1:0] dbus,
  output logic             busy,
  output logic             done,
  output logic             aIsZero,
  output logic             flagCarry,
  output logic             flagZero,
  output logic             flagNeg,
  output logic             flagOverflow
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  flags_t           flags_q, flags_d;
  logic             fe_q, fe_d;

  logic             mul_load;
  logic             mul_finished;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  logic             cin, si;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  alu_gen_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (resetBar),
    .load_i     (mul_load),
    .a_i        (areg),
    .b_i        (breg),
    .finished_o (mul_finished),
    .lo_o       (mul_lo),
    .hi_o       (mul_hi)
  );

  // Single-cycle datapath; only consumed on the accepting edge in IDLE.
  always_comb begin
    cin         = flags_q.c & doCarryIn;
    si          = flags_q.c & doShiftIn;
    sum         = '0;
    alu_res     = '0;
    alu_flags   = flags_q;
    alu_flags.v = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        sum         = {1'b0, areg} + {1'b0, breg} + (WIDTH + 1)'(cin);
        alu_res     = sum[WIDTH-1:0];
        alu_flags.c = sum[WIDTH];
        alu_flags.v = (areg[MSB] == breg[MSB]) && (alu_res[MSB] != areg[MSB]);
      end
      OP_SUB: begin
        alu_res     = areg - breg;
        alu_flags.c = (areg >= breg);
        alu_flags.v = (areg[MSB] != breg[MSB]) && (alu_res[MSB] != areg[MSB]);
      end
      OP_AND: alu_res = areg & breg;
      OP_OR:  alu_res = areg | breg;
      OP_XOR: alu_res = areg ^ breg;
      OP_SHR: begin
        alu_res     = {si, areg[MSB:1]};
        alu_flags.c = areg[0];
      end
      OP_SHL: begin
        alu_res     = {areg[MSB-1:0], si};
        alu_flags.c = areg[MSB];
      end
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[MSB];
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    fe_d     = fe_q;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fe_d = flagEnable;
          if (op_e'(op) == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
            if (flagEnable) flags_d = alu_flags;
          end
        end
      end
      ST_MUL: begin
        if (mul_finished) begin
          result_d = mul_lo;
          hi_d     = mul_hi;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          if (fe_q) begin
            flags_d.c = (mul_hi != '0);
            flags_d.v = (mul_hi != '0);
            flags_d.z = (mul_lo == '0);
            flags_d.n = mul_lo[MSB];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= FLAGS_CLEAR;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      fe_q     <= fe_d;
    end
  end

  // assertBarR wins over assertBarH; the bus is released when neither is low.
  assign dbus = !assertBarR ? result_q :
                !assertBarH ? hi_q     : 'z;

  assign busy         = (state_q == ST_MUL);
  assign done         = done_q;
  assign aIsZero      = (areg == '0);
  assign flagCarry    = flags_q.c;
  assign flagZero     = flags_q.z;
  assign flagNeg      = flags_q.n;
  assign flagOverflow = flags_q.v;

endmodule

// File: tb/tb_alu_gen.sv
// Directed self-checking bench for alu_gen at WIDTH=8; inputs change and
// outputs are sampled on the falling clock edge.
module tb_alu_gen;
  import alu_gen_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetBar, start, doCarryIn, doShiftIn, flagEnable;
  logic         assertBarR, assertBarH;
  logic [2:0]   op;
  logic [W-1:0] areg, breg;
  wire  [W-1:0] dbus;
  logic         busy, done, aIsZero;
  logic         flagCarry, flagZero, flagNeg, flagOverflow;
  logic         probe_en;
  logic [W-1:0] probe_val;
  int           checks = 0;
  int           failures = 0;

  wire [3:0] flags = {flagCarry, flagZero, flagNeg, flagOverflow};

  // Weak external driver used to show the DUT has released the bus.
  assign dbus = probe_en ? probe_val : 'z;

  always #5 clk = ~clk;

  alu_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetBar     (resetBar),
    .start        (start),
    .op           (op),
    .doCarryIn    (doCarryIn),
    .doShiftIn    (doShiftIn),
    .flagEnable   (flagEnable),
    .areg         (areg),
    .breg         (breg),
    .assertBarR   (assertBarR),
    .assertBarH   (assertBarH),
    .dbus         (dbus),
    .busy         (busy),
    .done         (done),
    .aIsZero      (aIsZero),
    .flagCarry    (flagCarry),
    .flagZero     (flagZero),
    .flagNeg      (flagNeg),
    .flagOverflow (flagOverflow)
  );

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sh, input logic fe);
    @(negedge clk);
    op = o; areg = a; breg = b; doCarryIn = ci; doShiftIn = sh; flagEnable = fe;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic get_result(output logic [W-1:0] v);
    assertBarR = 1'b0; assertBarH = 1'b1;
    #1 v = dbus;
  endtask

  task automatic get_hi(output logic [W-1:0] v);
    assertBarR = 1'b1; assertBarH = 1'b0;
    #1 v = dbus;
    assertBarR = 1'b0; assertBarH = 1'b1;
  endtask

  task automatic test_reset;
    logic [W-1:0] v;
    resetBar = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    get_result(v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", v); end
    get_hi(v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_hi got=%h exp=00", v); end
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic test_add;
    logic [W-1:0] v;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_idle_done got=%b exp=0", done); end
    run_op(OP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", done); end
    get_result(v);
    checks++; if (v !== 8'h10) begin failures++; $display("FAIL add_result got=%h exp=10", v); end
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL add_flags CZNV got=%b exp=1000", flags); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_width got=%b exp=0", done); end
  endtask

  task automatic test_sub;
    logic [W-1:0] v;
    run_op(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1);
    get_result(v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL sub_eq_result got=%h exp=00", v); end
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL sub_eq_flags CZNV got=%b exp=1100", flags); end
    run_op(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b0, 1'b1);
    get_result(v);
    checks++; if (v !== 8'hFE) begin failures++; $display("FAIL sub_lt_result got=%h exp=fe", v); end
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL sub_lt_flags CZNV got=%b exp=0010", flags); end
  endtask

  task automatic test_mul;
    logic [W-1:0] v;
    int n;
    logic early_done;
    run_op(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    n = 0; early_done = 1'b0;
    while (busy === 1'b1 && n < 20) begin
      if (done !== 1'b0) early_done = 1'b1;
      n++;
      if (n == 3) begin
        start = 1'b1; op = OP_ADD; areg = 8'h01; breg = 8'h01; flagEnable = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (n != 8) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=8", n); end
    checks++; if (early_done !== 1'b0) begin failures++; $display("FAIL mul_early_done got=%b exp=0", early_done); end
    checks++; if ({busy, done} !== 2'b01) begin failures++; $display("FAIL mul_done got=%b exp=01", {busy, done}); end
    get_result(v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL mul_result got=%h exp=01", v); end
    get_hi(v);
    checks++; if (v !== 8'hFE) begin failures++; $display("FAIL mul_hi got=%h exp=fe", v); end
    checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL mul_flags CZNV got=%b exp=1001", flags); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL mul_after got=%b exp=00", {busy, done}); end
  endtask

  // Runs right after MUL so flagCarry starts at 1.
  task automatic test_shift_logic;
    logic [2:0]   t_op  [8] = '{OP_SHR, OP_ADD, OP_SHL, OP_ADD, OP_SHL, OP_XOR, OP_AND, OP_OR};
    logic [W-1:0] t_a   [8] = '{8'h02, 8'hFF, 8'h81, 8'h7F, 8'h80, 8'h0F, 8'hF0, 8'h00};
    logic [W-1:0] t_b   [8] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h3C, 8'h00};
    logic         t_ci  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         t_si  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         t_fe  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] t_res [8] = '{8'h81, 8'h00, 8'h02, 8'h80, 8'h00, 8'hFF, 8'h30, 8'h00};
    logic [3:0]   t_flg [8] = '{4'b0010, 4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b1010, 4'b1000, 4'b1100};
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_ci[i], t_si[i], t_fe[i]);
      get_result(v);
      checks++; if (v !== t_res[i]) begin failures++; $display("FAIL vec%0d_result got=%h exp=%h", i, v, t_res[i]); end
      checks++; if (flags !== t_flg[i]) begin failures++; $display("FAIL vec%0d_flags CZNV got=%b exp=%b", i, flags, t_flg[i]); end
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [W-1:0] v;
    logic saw;
    run_op(OP_MUL, 8'h0F, 8'h03, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    resetBar = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL abort_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL abort_flags got=%b exp=0000", flags); end
    get_result(v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL abort_result got=%h exp=00", v); end
    get_hi(v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL abort_hi got=%h exp=00", v); end
    repeat (2) @(negedge clk);
    resetBar = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw); end
    run_op(OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_add_done got=%b exp=1", done); end
    get_result(v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL abort_add_result got=%h exp=02", v); end
  endtask

  task automatic test_dbus;
    int n;
    run_op(OP_MUL, 8'h13, 8'h11, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL dbus_mul_timeout got=%b exp=1", done); end
    assertBarR = 1'b0; assertBarH = 1'b1; #1;
    checks++; if (dbus !== 8'h43) begin failures++; $display("FAIL dbus_r got=%h exp=43", dbus); end
    assertBarR = 1'b1; assertBarH = 1'b0; #1;
    checks++; if (dbus !== 8'h01) begin failures++; $display("FAIL dbus_h got=%h exp=01", dbus); end
    assertBarR = 1'b0; assertBarH = 1'b0; #1;
    checks++; if (dbus !== 8'h43) begin failures++; $display("FAIL dbus_both got=%h exp=43", dbus); end
    assertBarR = 1'b1; assertBarH = 1'b1;
    probe_en = 1'b1; probe_val = 8'hA5; #1;
    checks++; if (dbus !== 8'hA5) begin failures++; $display("FAIL dbus_release_a5 got=%h exp=a5", dbus); end
    probe_val = 8'h5A; #1;
    checks++; if (dbus !== 8'h5A) begin failures++; $display("FAIL dbus_release_5a got=%h exp=5a", dbus); end
    probe_en = 1'b0;
    assertBarR = 1'b0; assertBarH = 1'b1;
  endtask

  task automatic test_a_is_zero;
    areg = 8'h00; #1;
    checks++; if (aIsZero !== 1'b1) begin failures++; $display("FAIL azero_zero got=%b exp=1", aIsZero); end
    areg = 8'h05; #1;
    checks++; if (aIsZero !== 1'b0) begin failures++; $display("FAIL azero_nonzero got=%b exp=0", aIsZero); end
  endtask

  initial begin
    resetBar = 1'b1; start = 1'b0; op = 3'd0; doCarryIn = 1'b0; doShiftIn = 1'b0;
    flagEnable = 1'b0; areg = '0; breg = '0; assertBarR = 1'b0; assertBarH = 1'b1;
    probe_en = 1'b0; probe_val = '0;
    #2;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_shift_logic;
    test_reset_mid_mul;
    test_dbus;
    test_a_is_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
